// File: rtl/dpmem_ls.sv
// Dual-port byte-writable load/store memory, cleared word by word after reset.
// Loads are registered (1 cycle); same-address store/load forwards write-first, A wins byte ties.
module dpmem_ls #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ready,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [DATA_W/8-1:0]   b_be,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_rvalid,
    output logic                  collision
);
    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_st, a_ld, b_st, b_ld;
    logic [DATA_W-1:0] word_a, word_b;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] dat,
                                                input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = dat[8*i +: 8];
        end
        return r;
    endfunction

    assign ready = (state == S_RUN);
    assign a_st  = ready & a_req & a_we;
    assign a_ld  = ready & a_req & ~a_we;
    assign b_st  = ready & b_req & b_we;
    assign b_ld  = ready & b_req & ~b_we;

    // Post-store word at each port's address: B's bytes first, then A's so A wins overlaps.
    always_comb begin
        word_a = mem[a_addr];
        if (b_st && b_addr == a_addr) word_a = merge(word_a, b_wdata, b_be);
        if (a_st) word_a = merge(word_a, a_wdata, a_be);
        word_b = mem[b_addr];
        if (b_st) word_b = merge(word_b, b_wdata, b_be);
        if (a_st && a_addr == b_addr) word_b = merge(word_b, a_wdata, a_be);
    end

    // Array has no reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[cnt] <= '0;
        end else begin
            if (a_st) mem[a_addr] <= word_a;
            if (b_st) mem[b_addr] <= word_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            cnt       <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            collision <= 1'b0;
        end else begin
            if (state == S_INIT) begin
                cnt <= cnt + ADDR_W'(1);
                if (cnt == ADDR_W'(DEPTH - 1)) state <= S_RUN;
            end
            a_rvalid  <= a_ld;
            b_rvalid  <= b_ld;
            if (a_ld) a_rdata <= word_a;
            if (b_ld) b_rdata <= word_b;
            collision <= a_st & b_st & (a_addr == b_addr) & (|(a_be & b_be));
        end
    end
endmodule
